// File: rtl/mem_tagged_responder_pkg.sv
// mem_tagged_responder_pkg: shared requester ids and responder state encoding
package mem_tagged_responder_pkg;
  localparam logic [1:0] ID_NONE = 2'd0;
  localparam logic [1:0] ID_DC = 2'd1;
  localparam logic [1:0] ID_IC = 2'd2;
  typedef enum logic [1:0] {CLEAR, RUN, STALL} state_t;
endpackage

// File: rtl/mem_tagged_responder_bram_be.sv
// mem_tagged_responder_bram_be: single-port block RAM with byte enables and registered read
module mem_tagged_responder_bram_be #(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [3:0]        we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem [2**ADDR_W];
  // byte-masked write; read data only moves on a real read so it holds between responses
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) if (we[i]) mem[addr][8*i+:8] <= wdata[8*i+:8];
    rdata <= rst ? '0 : re ? mem[addr] : rdata;
  end
endmodule

// File: rtl/mem_tagged_responder.sv
// mem_tagged_responder: tagged word memory target with fixed read latency and optional periodic stall
module mem_tagged_responder
  import mem_tagged_responder_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int LATENCY      = 2,
  parameter int CLEAR_ON_RST = 1,
  parameter int STALL_PERIOD = 0,
  parameter int STALL_LEN    = 2
) (
  input  logic        clock,
  input  logic        rst,
  output logic        mem_waitrequest,
  input  logic [1:0]  mem_id,
  input  logic [29:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_writedata,
  input  logic [3:0]  mem_writedatamask,
  output logic [31:0] mem_readdata,
  output logic [1:0]  mem_readdataid,
  output logic        proto_err
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_q;
  logic [15:0] cnt_q, cnt_d;
  logic wait_q, rd, wr, clearing, run_end, stall_end, unused_addr;
  logic [31:0] ram_q;
  logic [1:0] id_q [LATENCY];
  assign unused_addr = ^mem_address[29:ADDR_W];
  assign mem_waitrequest = wait_q;
  assign clearing = state_q == CLEAR;
  assign wr = mem_write & ~wait_q;
  assign rd = mem_read & ~mem_write & ~wait_q & (mem_id != ID_NONE);
  assign run_end = STALL_PERIOD != 0 && cnt_q == 16'(STALL_PERIOD - 1);
  assign stall_end = cnt_q == 16'(STALL_LEN - 1);
  assign mem_readdataid = id_q[LATENCY-1];
  mem_tagged_responder_bram_be #(.ADDR_W(ADDR_W)) u_ram (
    .clock(clock),
    .rst(rst),
    .we(clearing ? 4'hf : wr ? mem_writedatamask : 4'h0),
    .re(rd),
    .addr(clearing ? clr_q : mem_address[ADDR_W-1:0]),
    .wdata(clearing ? '0 : mem_writedata),
    .rdata(ram_q)
  );
  // next state: clear sweep, then run/stall alternation; counter restarts on every state change
  always_comb begin
    state_d = clearing ? (&clr_q ? RUN : CLEAR) : state_q == RUN ? (run_end ? STALL : RUN) : (stall_end ? RUN : STALL);
    cnt_d = state_d == state_q ? cnt_q + 16'd1 : '0;
  end
  // state, counters, registered waitrequest and sticky protocol error
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= CLEAR_ON_RST != 0 ? CLEAR : RUN;
      clr_q <= '0;
      cnt_q <= '0;
      wait_q <= 1'b1;
      proto_err <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q <= clearing ? clr_q + ADDR_W'(1) : clr_q;
      cnt_q <= cnt_d;
      wait_q <= state_d != RUN;
      proto_err <= proto_err | (mem_read & mem_write & ~wait_q);
    end
  end
  // id shift: stage 0 aligns with the RAM output register, a nonzero id marks a live response
  always_ff @(posedge clock) begin
    id_q[0] <= rst ? ID_NONE : rd ? mem_id : ID_NONE;
    for (int i = 1; i < LATENCY; i++) id_q[i] <= rst ? ID_NONE : id_q[i-1];
  end
  if (LATENCY == 1) begin : g_direct
    assign mem_readdata = ram_q;
  end else begin : g_pipe
    logic [31:0] d_q [LATENCY-1];
    assign mem_readdata = d_q[LATENCY-2];
    // data advances only alongside a live id so the output holds between responses
    always_ff @(posedge clock) begin
      d_q[0] <= rst ? '0 : id_q[0] != ID_NONE ? ram_q : d_q[0];
      for (int i = 1; i < LATENCY-1; i++) d_q[i] <= rst ? '0 : id_q[i] != ID_NONE ? d_q[i-1] : d_q[i];
    end
  end
endmodule

// File: tb/tb_mem_tagged_responder.sv
// tb_mem_tagged_responder: model-checked directed bench for mem_tagged_responder
module tb_mem_tagged_responder;
  import mem_tagged_responder_pkg::*;
  localparam int AW = 4, LAT = 3, PER = 8, SLEN = 2, CLR = 16;
  logic clock = 0, rst = 1, mem_read = 0, mem_write = 0;
  logic mem_waitrequest, proto_err;
  logic [1:0] mem_id = 0, mem_readdataid;
  logic [29:0] mem_address = 0;
  logic [31:0] mem_writedata = 0, mem_readdata;
  logic [3:0] mem_writedatamask = 0;
  int n_chk = 0, n_fail = 0;
  always #5 clock = ~clock;
  mem_tagged_responder #(.ADDR_W(AW), .LATENCY(LAT), .CLEAR_ON_RST(1), .STALL_PERIOD(PER), .STALL_LEN(SLEN)) dut (
    .clock(clock),
    .rst(rst),
    .mem_waitrequest(mem_waitrequest),
    .mem_id(mem_id),
    .mem_address(mem_address),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_writedata(mem_writedata),
    .mem_writedatamask(mem_writedatamask),
    .mem_readdata(mem_readdata),
    .mem_readdataid(mem_readdataid),
    .proto_err(proto_err)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: t is the cycle index since reset release; 16 clear cycles, then 8 open / 2 stalled forever
  typedef struct {int due; logic [1:0] id; logic [31:0] d;} rsp_t;
  rsp_t pend[$];
  logic [31:0] mdl [16];
  int t = 0;
  logic perr = 0;
  function automatic logic exp_wait(input int c);
    return c < CLR || (c - CLR) % (PER + SLEN) >= PER;
  endfunction
  always @(posedge clock) begin
    if (rst) begin
      t = 0;
      pend.delete();
      perr = 0;
      foreach (mdl[i]) mdl[i] = 0;
    end else begin
      if (!exp_wait(t) && (mem_read || mem_write)) begin
        if (mem_write) begin
          for (int b = 0; b < 4; b++) if (mem_writedatamask[b]) mdl[mem_address[3:0]][8*b+:8] = mem_writedata[8*b+:8];
          perr |= mem_read;
        end else if (mem_id != ID_NONE) pend.push_back('{t + LAT, mem_id, mdl[mem_address[3:0]]});
      end
      t++;
    end
  end
  always @(negedge clock) begin
    logic [1:0] eid;
    eid = (pend.size() > 0 && pend[0].due == t) ? pend[0].id : ID_NONE;
    chk("waitrequest", 32'(mem_waitrequest), 32'(exp_wait(t)));
    chk("readdataid", 32'(mem_readdataid), 32'(eid));
    chk("proto_err", 32'(proto_err), 32'(perr));
    if (eid != ID_NONE) begin
      chk("readdata", mem_readdata, pend[0].d);
      void'(pend.pop_front());
    end
  end
  task automatic req(input logic rd, input logic wr, input int a, input logic [31:0] d, input logic [3:0] m, input logic [1:0] id);
    int n = 0;
    mem_read = rd;
    mem_write = wr;
    mem_address = 30'(a);
    mem_writedata = d;
    mem_writedatamask = m;
    mem_id = id;
    while (mem_waitrequest && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) chk("accept_bound", 32'(n), 0);
    @(negedge clock);
    mem_read = 0;
    mem_write = 0;
  endtask
  task automatic lit_read(input int a, input logic [1:0] id, input logic [31:0] exp, input string nm);
    req(1, 0, a, 0, 0, id);
    repeat (LAT - 2) @(negedge clock);
    chk({nm, "_early"}, 32'(mem_readdataid), 0);
    @(negedge clock);
    chk({nm, "_id"}, 32'(mem_readdataid), 32'(id));
    chk({nm, "_data"}, mem_readdata, exp);
  endtask
  task automatic sync_run();
    int n = 0;
    while (!mem_waitrequest && n < 50) begin
      @(negedge clock);
      n++;
    end
    while (mem_waitrequest && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) chk("sync_bound", 32'(n), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n, seen;
    repeat (3) @(negedge clock);
    rst = 0;
    n = 0;
    while (mem_waitrequest && n < 50) begin
      n++;
      @(negedge clock);
    end
    chk("clear_cycles", 32'(n), 16);
    lit_read(5, ID_DC, 32'h0, "clear_rd5");
    req(0, 1, 3, 32'hDEADBEEF, 4'hf, ID_DC);
    req(0, 1, 3, 32'h000000AA, 4'h1, ID_DC);
    lit_read(3, ID_DC, 32'hDEADBEAA, "wr_mask");
    req(0, 1, 0, 32'h10000000, 4'hf, ID_DC);
    req(0, 1, 1, 32'h22221111, 4'hf, ID_DC);
    req(0, 1, 2, 32'h33330002, 4'hf, ID_DC);
    req(0, 1, 2, 32'hFFFFFFFF, 4'h0, ID_DC);
    sync_run();
    req(1, 0, 0, 0, 0, ID_IC);
    req(1, 0, 1, 0, 0, ID_DC);
    req(1, 0, 2, 0, 0, ID_IC);
    chk("b2b0_id", 32'(mem_readdataid), 32'(ID_IC));
    chk("b2b0_data", mem_readdata, 32'h10000000);
    @(negedge clock);
    chk("b2b1_id", 32'(mem_readdataid), 32'(ID_DC));
    chk("b2b1_data", mem_readdata, 32'h22221111);
    @(negedge clock);
    chk("b2b2_id", 32'(mem_readdataid), 32'(ID_IC));
    chk("b2b2_data", mem_readdata, 32'h33330002);
    seen = 0;
    fork
      for (int i = 0; i < 25; i++) req(1, 0, i % 16, 0, 0, (i % 2 == 0) ? ID_DC : ID_IC);
      repeat (45) begin
        @(negedge clock);
        seen += (mem_readdataid != ID_NONE) ? 1 : 0;
      end
    join
    chk("burst_rsp", 32'(seen), 25);
    sync_run();
    n = 0;
    repeat (20) begin
      n += mem_waitrequest ? 1 : 0;
      @(negedge clock);
    end
    chk("stall_window", 32'(n), 4);
    sync_run();
    req(1, 0, 3, 0, 0, ID_DC);
    rst = 1;
    seen = 0;
    repeat (3) begin
      @(negedge clock);
      seen += (mem_readdataid != ID_NONE) ? 1 : 0;
    end
    rst = 0;
    n = 0;
    while (mem_waitrequest && n < 50) begin
      seen += (mem_readdataid != ID_NONE) ? 1 : 0;
      n++;
      @(negedge clock);
    end
    chk("rst_drop", 32'(seen), 0);
    chk("clear_cycles2", 32'(n), 16);
    req(1, 1, 7, 32'h11, 4'hf, ID_DC);
    chk("proto_set", 32'(proto_err), 1);
    lit_read(7, ID_DC, 32'h11, "rw_write");
    repeat (5) @(negedge clock);
    chk("proto_sticky", 32'(proto_err), 1);
    rst = 1;
    repeat (2) @(negedge clock);
    chk("proto_clr", 32'(proto_err), 0);
    chk("rst_wait", 32'(mem_waitrequest), 1);
    rst = 0;
    repeat (20) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
